// File: rtl/uart_pkg.sv
// uart_pkg: shared launch-FSM encodings and default sizing for the UART transmit path.
package uart_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } tx_state_e;
  localparam int CLKS_PER_BIT   = 868;
  localparam int DEF_DEPTH_LOG2 = 4;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous byte FIFO whose pointers carry an extra wrap bit to tell full from empty.
module uart_sync_fifo import uart_pkg::*; #(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic [7:0]          wr_data,
  output logic [7:0]          rd_data,
  output logic [DEPTH_LOG2:0] level,
  output logic                empty,
  output logic                full
);
  logic [7:0]          mem_q [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                do_push, do_pop;
  always_comb begin
    level    = wr_ptr_q - rd_ptr_q;
    empty    = level == '0;
    full     = level[DEPTH_LOG2];
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + (DEPTH_LOG2+1)'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + (DEPTH_LOG2+1)'(1) : rd_ptr_q;
    rd_data  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
  end
endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte queue feeding a UART transmitter, pacing launches from its active/done status.
// Define UART_TXQ_OVF_EN to add the sticky overflow flag (o_OVF) and its clear input (i_OVF_CLR).
module uart_tx_queue import uart_pkg::*; #(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_WR_DV,
  input  logic [7:0]          i_WR_BYTE,
  output logic                o_WR_READY,
  output logic                o_TX_DV,
  output logic [7:0]          o_TX_BYTE,
  input  logic                i_TX_ACTIVE,
  input  logic                i_TX_DONE,
  output logic [DEPTH_LOG2:0] o_LEVEL,
  output logic                o_EMPTY,
  output logic                o_FULL
`ifdef UART_TXQ_OVF_EN
  ,
  input  logic                i_OVF_CLR,
  output logic                o_OVF
`endif
);
  tx_state_e  state_q, state_d;
  logic [7:0] byte_q, byte_d, head;
  logic       pop;
  uart_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk    (i_Clk),
    .rst    (i_Rst),
    .push   (i_WR_DV),
    .pop    (pop),
    .wr_data(i_WR_BYTE),
    .rd_data(head),
    .level  (o_LEVEL),
    .empty  (o_EMPTY),
    .full   (o_FULL)
  );
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= IDLE;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
    end
  end
  // Launch only once the transmitter is idle and past its done cleanup, so data-valid is never ignored.
  always_comb begin
    state_d = (state_q == IDLE) ? ((!o_EMPTY && !i_TX_ACTIVE && !i_TX_DONE) ? REQ : IDLE) :
              (state_q == REQ)  ? (i_TX_ACTIVE ? BUSY : REQ) :
                                  (i_TX_ACTIVE ? BUSY : IDLE);
  end
  always_comb begin
    o_TX_DV    = state_q == REQ;
    pop        = state_q == IDLE && state_d == REQ;
    byte_d     = pop ? head : byte_q;
    o_TX_BYTE  = byte_q;
    o_WR_READY = !o_FULL;
  end
`ifdef UART_TXQ_OVF_EN
  logic ovf_q, ovf_d;
  always_comb ovf_d = (i_WR_DV && o_FULL) ? 1'b1 : i_OVF_CLR ? 1'b0 : ovf_q;
  always_ff @(posedge i_Clk) begin
    if (i_Rst) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end
  assign o_OVF = ovf_q;
`endif
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: scoreboard bench pairing uart_tx_queue with a behavioural transmitter at 4 clocks per bit.
module tb_uart_tx_queue;
  localparam int DL = 4, DEPTH = 16, CPB = 4;
  logic clk = 0, rst = 1, wr_dv = 0;
  logic [7:0] wr_byte = 0;
  logic wr_ready, tx_dv, o_empty, o_full;
  logic [7:0] tx_byte;
  logic [DL:0] level;
  logic tx_active = 0, tx_done = 0;
  int tx_st = 0, tx_cnt = 0;
  int vectors = 0, miscompares = 0, cyc = 0, rises = 0, accepts = 0, rise_cyc = 0, fall_cyc = 0;
  bit gap_armed = 0;
  logic dv_prev = 0, act_prev = 0, done_prev = 0;
  logic [7:0] last_pop = 0;
  logic [7:0] exp_q[$];
`ifdef UART_TXQ_OVF_EN
  logic ovf_clr = 0, o_ovf;
  bit m_ovf = 0;
`endif

  always #5 clk = ~clk;

  uart_tx_queue #(.DEPTH_LOG2(DL)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_WR_DV(wr_dv), .i_WR_BYTE(wr_byte), .o_WR_READY(wr_ready),
    .o_TX_DV(tx_dv), .o_TX_BYTE(tx_byte), .i_TX_ACTIVE(tx_active), .i_TX_DONE(tx_done),
    .o_LEVEL(level), .o_EMPTY(o_empty), .o_FULL(o_full)
`ifdef UART_TXQ_OVF_EN
    , .i_OVF_CLR(ovf_clr), .o_OVF(o_ovf)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transmitter: accepts data-valid only in idle, frame of 10 bit times, done high in cleanup and first idle cycle.
  initial forever begin
    @(posedge clk);
    if (tx_st == 2) chk("dv_in_cleanup", tx_dv, 0);
    case (tx_st)
      0: begin
        tx_done <= 0;
        if (tx_dv) begin
          accepts++;
          chk("tx_byte_stable", tx_byte, last_pop);
          tx_active <= 1; tx_cnt <= 0; tx_st <= 1;
        end
      end
      1: begin
        if (tx_cnt < 10*CPB-1) tx_cnt <= tx_cnt + 1;
        else begin tx_active <= 0; tx_done <= 1; tx_st <= 2; end
      end
      default: begin tx_done <= 1; tx_st <= 0; end
    endcase
  end

  // Reference model: queue of bytes accepted and not yet launched.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
`ifdef UART_TXQ_OVF_EN
      m_ovf = 0;
`endif
    end else begin
`ifdef UART_TXQ_OVF_EN
      if (wr_dv && exp_q.size() == DEPTH) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
`endif
      if (wr_dv && exp_q.size() < DEPTH) exp_q.push_back(wr_byte);
    end
  end

  // Monitor: pops the scoreboard on each launch and checks occupancy every cycle.
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin chk("dv_after_rst", tx_dv, 0); gap_armed = 0; end
    if (tx_dv && !dv_prev) begin
      rises++;
      chk("launch_guard", {act_prev, done_prev}, 0);
      if (gap_armed) chk("gap", cyc - fall_cyc, 3);
      gap_armed = 0;
      if (exp_q.size() == 0) chk("spurious_dv", tx_dv, 0);
      else begin
        chk("tx_byte", tx_byte, exp_q[0]);
        last_pop = exp_q.pop_front();
      end
      rise_cyc = cyc;
    end
    if (!tx_dv && dv_prev) chk("dv_width", cyc - rise_cyc, 2);
    if (!tx_active && act_prev) begin fall_cyc = cyc; gap_armed = exp_q.size() > 0; end
    chk("level", level, exp_q.size());
    chk("empty", o_empty, exp_q.size() == 0);
    chk("full", o_full, exp_q.size() == DEPTH);
    chk("ready", wr_ready, exp_q.size() != DEPTH);
`ifdef UART_TXQ_OVF_EN
    chk("ovf", o_ovf, m_ovf);
`endif
    dv_prev = tx_dv; act_prev = tx_active; done_prev = tx_done;
  end

  task automatic wr1(input logic [7:0] b);
    @(negedge clk);
    wr_dv = 1; wr_byte = b;
    @(negedge clk);
    wr_dv = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(exp_q.size() == 0 && tx_st == 0 && !tx_done && !tx_dv && !tx_active) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", n < 3000, 1);
  endtask

  initial begin
    int n, r0;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_level", level, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_full", o_full, 0);
    chk("rst_ready", wr_ready, 1);
    chk("rst_dv", tx_dv, 0);
    chk("rst_byte", tx_byte, 0);
`ifdef UART_TXQ_OVF_EN
    chk("rst_ovf", o_ovf, 0);
`endif
    // Single byte: data-valid one edge after the write, two cycles wide.
    wr1(8'hA5);
    chk("lat_w0", tx_dv, 0);
    @(negedge clk); chk("lat_w1", tx_dv, 1);
    @(negedge clk); chk("lat_w2", tx_dv, 1);
    @(negedge clk); chk("lat_w3", tx_dv, 0);
    wait_idle();
    chk("a5_level", level, 0);
    // Back-to-back burst to full, then hammer writes while full.
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin wr_dv = 1; wr_byte = i[7:0]; @(negedge clk); end
    chk("burst_level", level, 15);
    wr_byte = 8'h10; @(negedge clk);
    chk("burst_full", o_full, 1);
    chk("burst_full_level", level, 16);
    wr_byte = 8'hFF;
    repeat (5) @(negedge clk);
    wr_dv = 0;
`ifdef UART_TXQ_OVF_EN
    chk("ovf_set", o_ovf, 1);
    ovf_clr = 1; @(negedge clk); ovf_clr = 0;
    chk("ovf_clr", o_ovf, 0);
`endif
    wait_idle();
    // Push and pop on the same edge at level 3.
    for (int i = 0; i < 4; i++) wr1(8'h30 + 8'(i));
    chk("pp_pre_level", level, 3);
    n = 0;
    do begin @(negedge clk); n++; end while (!(tx_st == 0 && tx_done) && n < 200);
    chk("pp_timeout", n < 200, 1);
    wr1(8'h55);
    chk("pp_level", level, 3);
    chk("pp_dv", tx_dv, 1);
    wait_idle();
    // Reset during data bits with 4 bytes queued.
    for (int i = 0; i < 5; i++) wr1(8'h40 + 8'(i));
    chk("rst5_pre_level", level, 4);
    n = 0;
    while (!(tx_st == 1 && tx_cnt == 2*CPB) && n < 200) begin @(negedge clk); n++; end
    chk("rst5_timeout", n < 200, 1);
    rst = 1; @(negedge clk); rst = 0;
    chk("rst5_level", level, 0);
    chk("rst5_dv", tx_dv, 0);
    r0 = rises;
    n = 0;
    while (tx_st != 2 && n < 200) begin @(negedge clk); n++; end
    chk("rst5_frame_done", tx_st, 2);
    repeat (10) @(negedge clk);
    chk("rst5_no_launch", rises, r0);
    wait_idle();
    // Write landing in the transmitter's cleanup cycle waits for done to drop.
    wr1(8'h66);
    n = 0;
    while (tx_st != 2 && n < 200) begin @(negedge clk); n++; end
    chk("cl_timeout", tx_st, 2);
    wr_dv = 1; wr_byte = 8'h77;
    @(negedge clk); wr_dv = 0;
    chk("cl_dv0", tx_dv, 0);
    @(negedge clk); chk("cl_dv1", tx_dv, 0);
    @(negedge clk); chk("cl_dv2", tx_dv, 1);
    wait_idle();
    // Random traffic, often driving the queue full.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      wr_dv = ($urandom_range(0, 2) == 0);
      wr_byte = 8'($urandom);
`ifdef UART_TXQ_OVF_EN
      ovf_clr = ($urandom_range(0, 15) == 0);
`endif
    end
    @(negedge clk);
    wr_dv = 0;
`ifdef UART_TXQ_OVF_EN
    ovf_clr = 0;
`endif
    wait_idle();
    chk("sent_once", accepts, rises);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
